// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined ALU: opcodes, flag bit positions and FSM states.
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_NOT = 4'd4;
    localparam logic [3:0] OP_XOR = 4'd5;
    localparam logic [3:0] OP_SHL = 4'd6;
    localparam logic [3:0] OP_SHR = 4'd7;
    localparam logic [3:0] OP_MUL = 4'd8;

    localparam int FLAG_NEG   = 3;
    localparam int FLAG_ZERO  = 2;
    localparam int FLAG_OVF   = 1;
    localparam int FLAG_CARRY = 0;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    function automatic logic [3:0] pack_flags(input logic neg, input logic zero,
                                               input logic ovf, input logic carry);
        logic [3:0] f;
        f             = '0;
        f[FLAG_NEG]   = neg;
        f[FLAG_ZERO]  = zero;
        f[FLAG_OVF]   = ovf;
        f[FLAG_CARRY] = carry;
        return f;
    endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative unsigned shift-add multiplier: one partial product per cycle, N cycles per product.
// done and product are combinational on the final step so the caller can register them directly.
module alu_mul_iter
    import alu_pkg::*;
#(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           done,
    output logic [2*N-1:0] product
);

    localparam int CW = $clog2(N);

    logic           busy_q,   busy_d;
    logic [CW-1:0]  cnt_q,    cnt_d;
    logic [2*N-1:0] mcand_q,  mcand_d;
    logic [N-1:0]   mplier_q, mplier_d;
    logic [2*N-1:0] acc_q,    acc_d;
    logic [2*N-1:0] acc_step;

    assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign done     = busy_q && (cnt_q == CW'(N - 1));
    assign product  = acc_step;

    // NOTE: every _d gets its hold value first, so no path through this block infers a latch.
    always_comb begin
        busy_d   = busy_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        if (start) begin
            busy_d   = 1'b1;
            cnt_d    = '0;
            mcand_d  = {{N{1'b0}}, a};
            mplier_d = b;
            acc_d    = '0;
        end else if (busy_q) begin
            acc_d    = acc_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CW'(1);
            if (done) begin
                busy_d = 1'b0;
                cnt_d  = '0;
            end
        end
    end

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else begin
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready handshakes; single-cycle ops retire at 1/clk,
// MUL runs on the iterative multiplier and blocks the input while it works.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] opa,
    input  logic [N-1:0] opb,
    input  logic [3:0]   opcode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out,
    output logic [N-1:0] out_hi,
    output logic [3:0]   flags,
    output logic         err
);

    localparam int SHW = $clog2(N);

    state_e         state_q,     state_d;
    logic           out_valid_q, out_valid_d;
    logic [N-1:0]   out_q,       out_d;
    logic [N-1:0]   out_hi_q,    out_hi_d;
    logic [3:0]     flags_q,     flags_d;
    logic           err_q,       err_d;

    logic           accept;
    logic           mul_start;
    logic           mul_done;
    logic [2*N-1:0] product;

    logic [N:0]     sum;
    logic [N:0]     diff;
    logic [SHW-1:0] shamt;
    logic           shift_oob;
    logic [N-1:0]   res;
    logic           carry;
    logic           ovf;
    logic           illegal;
    logic [3:0]     alu_flags;

    assign in_ready  = (state_q == IDLE) && (!out_valid_q || out_ready);
    assign accept    = in_valid && in_ready;
    assign mul_start = accept && (opcode == OP_MUL);

    alu_mul_iter #(.N(N)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (opa),
        .b       (opb),
        .done    (mul_done),
        .product (product)
    );

    always_comb begin
        sum       = {1'b0, opa} + {1'b0, opb};
        diff      = {1'b0, opa} - {1'b0, opb};
        shamt     = opb[SHW-1:0];
        shift_oob = (int'(shamt) >= N);
        res       = '0;
        carry     = 1'b0;
        ovf       = 1'b0;
        illegal   = 1'b0;
        unique case (opcode)
            OP_ADD: begin
                res   = sum[N-1:0];
                carry = sum[N];
                ovf   = (opa[N-1] == opb[N-1]) && (sum[N-1] != opa[N-1]);
            end
            OP_SUB: begin
                res   = diff[N-1:0];
                carry = diff[N];
                ovf   = (opa[N-1] != opb[N-1]) && (diff[N-1] != opa[N-1]);
            end
            OP_AND:  res = opa & opb;
            OP_OR:   res = opa | opb;
            OP_NOT:  res = ~opa;
            OP_XOR:  res = opa ^ opb;
            OP_SHL:  res = shift_oob ? '0 : (opa << shamt);
            OP_SHR:  res = shift_oob ? '0 : (opa >> shamt);
            OP_MUL:  res = '0;
            default: illegal = 1'b1;
        endcase
        // Illegal opcodes report all-zero flags, including zero.
        alu_flags = illegal ? 4'b0 : pack_flags(res[N-1], res == '0, ovf, carry);
    end

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_d       = out_q;
        out_hi_d    = out_hi_q;
        flags_d     = flags_q;
        err_d       = err_q;
        if (out_ready) begin
            out_valid_d = 1'b0;
        end
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (opcode == OP_MUL) begin
                        state_d = BUSY;
                    end else begin
                        out_valid_d = 1'b1;
                        out_d       = res;
                        out_hi_d    = '0;
                        flags_d     = alu_flags;
                        err_d       = illegal;
                    end
                end
            end
            BUSY: begin
                if (mul_done) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b1;
                    out_d       = product[N-1:0];
                    out_hi_d    = product[2*N-1:N];
                    flags_d     = pack_flags(product[2*N-1], product == '0, 1'b0, 1'b0);
                    err_d       = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            out_hi_q    <= '0;
            flags_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            out_hi_q    <= out_hi_d;
            flags_q     <= flags_d;
            err_q       <= err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out       = out_q;
    assign out_hi    = out_hi_q;
    assign flags     = flags_q;
    assign err       = err_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe (N=8): stimulus pushes expected results into a queue,
// an independent monitor pops and compares each result the DUT hands over.
module tb_alu_pipe;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] opa;
    logic [7:0] opb;
    logic [3:0] opcode;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out;
    logic [7:0] out_hi;
    logic [3:0] flags;
    logic       err;

    int checks   = 0;
    int failures = 0;
    int pops     = 0;
    int cyc      = 0;

    // {err, flags, out_hi, out}
    logic [20:0] exp_q[$];

    alu_pipe #(.N(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opa       (opa),
        .opb       (opb),
        .opcode    (opcode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .out_hi    (out_hi),
        .flags     (flags),
        .err       (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_result: got %0h expected none", {err, flags, out_hi, out});
            end else begin
                check("result", 32'({err, flags, out_hi, out}), 32'(exp_q.pop_front()));
                pops++;
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 of the cycle after the accepting edge.
    task automatic send(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] e_lo, input logic [7:0] e_hi,
                        input logic [3:0] e_flags, input logic e_err);
        logic rdy;
        logic accepted;
        accepted = 1'b0;
        in_valid = 1'b1;
        opcode   = op;
        opa      = a;
        opb      = b;
        for (int i = 0; i < 50 && !accepted; i++) begin
            #1;
            rdy = in_ready;
            @(posedge clk);
            #1;
            if (rdy) accepted = 1'b1;
        end
        in_valid = 1'b0;
        if (!accepted) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: got no accept expected accept");
        end else begin
            exp_q.push_back({e_err, e_flags, e_hi, e_lo});
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int busy_cycles;
        int valid_at;
        int c0;
        int p0;
        int stale;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        opa       = '0;
        opb       = '0;
        opcode    = '0;
        out_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_outputs", 32'({err, flags, out_hi, out}), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // ADD with carry-out to zero; output valid right after the accepting edge.
        send(4'h0, 8'hFF, 8'h01, 8'h00, 8'h00, 4'b0101, 1'b0);
        check("add_latency_valid", 32'(out_valid), 32'd1);
        send(4'h1, 8'h80, 8'h01, 8'h7F, 8'h00, 4'b0010, 1'b0);
        send(4'h1, 8'h00, 8'h01, 8'hFF, 8'h00, 4'b1001, 1'b0);
        send(4'h0, 8'h7F, 8'h01, 8'h80, 8'h00, 4'b1010, 1'b0);
        send(4'h2, 8'hF0, 8'h3C, 8'h30, 8'h00, 4'b0000, 1'b0);
        send(4'h3, 8'h0F, 8'hF0, 8'hFF, 8'h00, 4'b1000, 1'b0);
        send(4'h4, 8'h00, 8'h55, 8'hFF, 8'h00, 4'b1000, 1'b0);
        send(4'h5, 8'hAA, 8'hAA, 8'h00, 8'h00, 4'b0100, 1'b0);
        send(4'h6, 8'h81, 8'h09, 8'h02, 8'h00, 4'b0000, 1'b0);
        send(4'h7, 8'h80, 8'h07, 8'h01, 8'h00, 4'b0000, 1'b0);
        send(4'hC, 8'h12, 8'h34, 8'h00, 8'h00, 4'b0000, 1'b1);
        drain();

        // MUL FF*FF: input blocked for 8 cycles, result valid in cycle 9.
        send(4'h8, 8'hFF, 8'hFF, 8'h01, 8'hFE, 4'b1000, 1'b0);
        busy_cycles = 0;
        valid_at    = 0;
        for (int k = 1; k <= 20 && valid_at == 0; k++) begin
            if (out_valid) valid_at = k;
            else begin
                if (!in_ready) busy_cycles++;
                @(posedge clk);
                #1;
            end
        end
        check("mul_busy_cycles", 32'(busy_cycles), 32'd8);
        check("mul_valid_cycle", 32'(valid_at), 32'd9);
        drain();
        send(4'h8, 8'h0D, 8'h0B, 8'h8F, 8'h00, 4'b0000, 1'b0);
        send(4'h8, 8'h00, 8'h05, 8'h00, 8'h00, 4'b0100, 1'b0);
        drain();

        // Backpressure: result must hold and input stay blocked.
        out_ready = 1'b0;
        send(4'h0, 8'h12, 8'h34, 8'h46, 8'h00, 4'b0000, 1'b0);
        for (int k = 0; k < 5; k++) begin
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_data", 32'({err, flags, out_hi, out}), 32'h00046);
            check("hold_in_ready", 32'(in_ready), 32'd0);
            @(posedge clk);
            #1;
        end

        // Release and stream 4 ADDs back to back.
        out_ready = 1'b1;
        c0 = cyc;
        p0 = pops;
        send(4'h0, 8'h01, 8'h02, 8'h03, 8'h00, 4'b0000, 1'b0);
        send(4'h0, 8'h10, 8'h20, 8'h30, 8'h00, 4'b0000, 1'b0);
        send(4'h0, 8'h40, 8'h40, 8'h80, 8'h00, 4'b1010, 1'b0);
        send(4'h0, 8'h80, 8'h80, 8'h00, 8'h00, 4'b0111, 1'b0);
        check("stream_cycles", 32'(cyc - c0), 32'd4);
        @(negedge clk);
        #1;
        check("stream_pops", 32'(pops - p0), 32'd5);
        drain();

        // Reset during MUL BUSY cycle 3.
        send(4'h8, 8'hFF, 8'hFF, 8'h01, 8'hFE, 4'b1000, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_outputs", 32'({err, flags, out_hi, out}), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        stale = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) stale++;
        end
        check("midrst_no_stale", 32'(stale), 32'd0);
        send(4'h0, 8'h05, 8'h06, 8'h0B, 8'h00, 4'b0000, 1'b0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
